// File: rtl/flash_boot_loader_pkg.sv
// Shared bus widths, default boot addresses and the loader state encoding.
package flash_boot_loader_pkg;

  localparam int WB_AddrBus = 32;
  localparam int WB_DataBus = 32;

  localparam logic [31:0] BootFlashBase = 32'h1E00_0000;
  localparam logic [31:0] BootRamBase   = 32'h0000_0000;

  typedef enum logic [3:0] {
    IDLE,
    RD_LO,
    GAP_LO,
    RD_HI,
    GAP_HI,
    WR,
    GAP_WR,
    DONE,
    ERR
  } boot_state_t;

  // Flash halfwords sit on 4-byte steps, so word j spans base + 8j and base + 8j + 4.
  function automatic logic [31:0] flash_addr(input logic [31:0] base, input logic [15:0] idx,
                                             input logic upper);
    return base + {13'd0, idx, upper, 2'b00};
  endfunction

endpackage

// File: rtl/flash_boot_loader_bus_master_port.sv
// Single-word bus initiator: registers a request, holds it until ack or timeout,
// then drops select so the next request always sees at least one idle cycle.
module flash_boot_loader_bus_master_port
  import flash_boot_loader_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [WB_AddrBus-1:0] req_addr,
  input  logic [WB_DataBus-1:0] req_data,
  input  logic                  req_we,
  output logic                  ack,
  output logic                  timeout,
  output logic [WB_AddrBus-1:0] bus_addr_o,
  output logic [WB_DataBus-1:0] bus_data_o,
  output logic                  bus_select_o,
  output logic                  bus_we_o,
  input  logic                  bus_ack_i
);

  localparam logic [15:0] LastWait = 16'(TIMEOUT - 1);

  logic [15:0] wait_cnt;

  assign ack     = bus_select_o && bus_ack_i;
  assign timeout = bus_select_o && !bus_ack_i && (wait_cnt == LastWait);

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_select_o <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_addr_o   <= '0;
      bus_data_o   <= '0;
      wait_cnt     <= '0;
    end else if (bus_select_o) begin
      // Address, data and we stay frozen; only select falls at the end.
      if (ack || timeout) begin
        bus_select_o <= 1'b0;
        wait_cnt     <= '0;
      end else begin
        wait_cnt <= wait_cnt + 16'd1;
      end
    end else if (req) begin
      bus_select_o <= 1'b1;
      bus_we_o     <= req_we;
      bus_addr_o   <= req_addr;
      bus_data_o   <= req_data;
      wait_cnt     <= '0;
    end
  end

endmodule

// File: rtl/flash_boot_loader.sv
// Copies WORD_COUNT words from 16-bit flash into 32-bit SRAM at power-up,
// stalling the CPU through halt_o until the copy finishes or times out.
module flash_boot_loader
  import flash_boot_loader_pkg::*;
#(
  parameter logic [31:0] FLASH_BASE = BootFlashBase,
  parameter logic [31:0] RAM_BASE   = BootRamBase,
  parameter int          WORD_COUNT = 1024,
  parameter int          TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic [WB_AddrBus-1:0] bus_addr_o,
  output logic [WB_DataBus-1:0] bus_data_o,
  input  logic [WB_DataBus-1:0] bus_data_i,
  output logic                  bus_select_o,
  output logic                  bus_we_o,
  input  logic                  bus_ack_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic                  halt_o
);

  localparam bit          Empty   = (WORD_COUNT == 0);
  localparam logic [15:0] LastIdx = 16'(WORD_COUNT - 1);

  boot_state_t state;
  logic [15:0] j;
  logic [15:0] lo;
  logic [15:0] hi;
  logic        busy;
  logic        done;
  logic        error;

  logic        req;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        ack;
  logic        timeout;
  logic        last;
  logic        unused_data_hi;

  assign last           = (j == LastIdx);
  assign unused_data_hi = ^bus_data_i[31:16];

  assign busy_o  = busy;
  assign halt_o  = busy;
  assign done_o  = done;
  assign error_o = error;

  // Requests are launched from the state preceding each RD/WR so select rises on entry.
  always_comb begin
    req      = 1'b0;
    req_we   = 1'b0;
    req_addr = FLASH_BASE;
    req_data = '0;
    case (state)
      IDLE, DONE, ERR: req = start_i && !Empty;
      GAP_LO: begin
        req      = 1'b1;
        req_addr = flash_addr(FLASH_BASE, j, 1'b1);
      end
      GAP_HI: begin
        req      = 1'b1;
        req_we   = 1'b1;
        req_addr = RAM_BASE + {14'd0, j, 2'b00};
        req_data = {hi, lo};
      end
      GAP_WR: begin
        req      = !last;
        req_addr = flash_addr(FLASH_BASE, j + 16'd1, 1'b0);
      end
      default: req = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      j     <= '0;
      lo    <= '0;
      hi    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start_i) begin
            done  <= Empty;
            error <= 1'b0;
            j     <= '0;
            busy  <= !Empty;
            state <= Empty ? DONE : RD_LO;
          end
        end
        RD_LO, RD_HI, WR: begin
          if (ack) begin
            if (state == RD_LO) lo <= bus_data_i[15:0];
            if (state == RD_HI) hi <= bus_data_i[15:0];
            state <= (state == RD_LO) ? GAP_LO : (state == RD_HI) ? GAP_HI : GAP_WR;
          end else if (timeout) begin
            busy  <= 1'b0;
            error <= 1'b1;
            state <= ERR;
          end
        end
        GAP_LO: state <= RD_HI;
        GAP_HI: state <= WR;
        GAP_WR: begin
          j <= j + 16'd1;
          if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= RD_LO;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  flash_boot_loader_bus_master_port #(
    .TIMEOUT(TIMEOUT)
  ) u_port (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_we      (req_we),
    .ack         (ack),
    .timeout     (timeout),
    .bus_addr_o  (bus_addr_o),
    .bus_data_o  (bus_data_o),
    .bus_select_o(bus_select_o),
    .bus_we_o    (bus_we_o),
    .bus_ack_i   (bus_ack_i)
  );

endmodule

// File: tb/tb_flash_boot_loader.sv
// Directed checks of the boot loader against three configurations and several responder behaviours.
module tb_flash_boot_loader;

  logic clk;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  // Instance A: WORD_COUNT=2, TIMEOUT=10, responder behaviour selected by mode.
  logic        start_a;
  logic [31:0] addr_a, dat_a, rdat_a;
  logic        sel_a, we_a, busy_a, done_a, err_a, halt_a;
  bit          ack_a;
  int          mode = 0;
  bit   [1:0]  wcnt;

  // Instance B: WORD_COUNT=6, zero-wait responder.
  logic        start_b;
  logic [31:0] addr_b, dat_b, rdat_b;
  logic        sel_b, we_b, busy_b, done_b, err_b, halt_b;

  // Instance C: WORD_COUNT=0, ack held high.
  logic        start_c;
  logic [31:0] addr_c, dat_c;
  logic        sel_c, we_c, busy_c, done_c, err_c, halt_c;

  logic [31:0] txn_q[$];
  logic [63:0] wr_q[$];
  int          stab_err = 0;
  int          gap_err  = 0;
  int          low_run  = 0;
  logic        p_sel = 0, p_ack = 0, p_we = 0, p_busy = 0;
  logic [31:0] p_addr = 0, p_dat = 0;

  function automatic logic [15:0] flash_hw(input logic [31:0] a);
    logic [31:0] k;
    k = (a - 32'h1E00_0000) >> 2;
    return (k[15:0] + 16'd1) * 16'h1111;
  endfunction

  assign rdat_a = {16'hDEAD, flash_hw(addr_a)};
  assign rdat_b = {16'hBEEF, flash_hw(addr_b)};

  always_comb begin
    case (mode)
      0:       ack_a = sel_a;
      1:       ack_a = sel_a && (wcnt == 2'd2);
      2:       ack_a = 1'b1;
      default: ack_a = 1'b0;
    endcase
  end

  always @(posedge clk) begin
    if (!sel_a || ack_a) wcnt <= 2'd0;
    else                 wcnt <= wcnt + 2'd1;
  end

  always @(negedge clk) begin
    if (sel_a && ack_a) begin
      txn_q.push_back(addr_a);
      if (we_a) wr_q.push_back({addr_a, dat_a});
    end
    if (sel_a) begin
      if (p_sel && !p_ack && (addr_a !== p_addr || we_a !== p_we || dat_a !== p_dat)) stab_err++;
      if (p_sel && p_ack) gap_err++;
      if (!p_sel && p_busy && low_run != 1) gap_err++;
      low_run = 0;
    end else begin
      low_run++;
    end
    p_sel  = sel_a;
    p_ack  = ack_a;
    p_addr = addr_a;
    p_we   = we_a;
    p_dat  = dat_a;
    p_busy = busy_a;
  end

  flash_boot_loader #(.WORD_COUNT(2), .TIMEOUT(10)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_a),
    .bus_addr_o(addr_a), .bus_data_o(dat_a), .bus_data_i(rdat_a),
    .bus_select_o(sel_a), .bus_we_o(we_a), .bus_ack_i(ack_a),
    .busy_o(busy_a), .done_o(done_a), .error_o(err_a), .halt_o(halt_a)
  );

  flash_boot_loader #(.WORD_COUNT(6), .TIMEOUT(20)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b),
    .bus_addr_o(addr_b), .bus_data_o(dat_b), .bus_data_i(rdat_b),
    .bus_select_o(sel_b), .bus_we_o(we_b), .bus_ack_i(sel_b),
    .busy_o(busy_b), .done_o(done_b), .error_o(err_b), .halt_o(halt_b)
  );

  flash_boot_loader #(.WORD_COUNT(0)) dut_c (
    .clk(clk), .rst(rst), .start_i(start_c),
    .bus_addr_o(addr_c), .bus_data_o(dat_c), .bus_data_i(32'h0),
    .bus_select_o(sel_c), .bus_we_o(we_c), .bus_ack_i(1'b1),
    .busy_o(busy_c), .done_o(done_c), .error_o(err_c), .halt_o(halt_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_done_a(inout int cyc);
    while (!done_a && !err_a && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int tb0, wb0, se0, ge0;
    logic [31:0] exp_addr [6];

    exp_addr[0] = 32'h1E00_0000; exp_addr[1] = 32'h1E00_0004; exp_addr[2] = 32'h0000_0000;
    exp_addr[3] = 32'h1E00_0008; exp_addr[4] = 32'h1E00_000C; exp_addr[5] = 32'h0000_0004;

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    chk("rst_sel", sel_a, 0);   chk("rst_we", we_a, 0);     chk("rst_addr", addr_a, 0);
    chk("rst_data", dat_a, 0);  chk("rst_busy", busy_a, 0); chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);   chk("rst_halt", halt_a, 0);

    // Zero-wait copy of two words
    mode = 0; wb0 = wr_q.size(); se0 = stab_err; ge0 = gap_err;
    start_a = 1'b1; tick(); start_a = 1'b0; cyc = 1;
    chk("zw_first_sel", sel_a, 1);  chk("zw_first_addr", addr_a, 32'h1E00_0000);
    chk("zw_first_we", we_a, 0);    chk("zw_busy", busy_a, 1); chk("zw_halt", halt_a, 1);
    wait_done_a(cyc);
    chk("zw_done_cycles", cyc, 13); chk("zw_busy_end", busy_a, 0); chk("zw_halt_end", halt_a, 0);
    chk("zw_err", err_a, 0);        chk("zw_nwr", wr_q.size() - wb0, 2);
    chk("zw_wr0", wr_q[wb0], 64'h0000_0000_2222_1111);
    chk("zw_wr1", wr_q[wb0 + 1], 64'h0000_0004_4444_3333);
    chk("zw_gap", gap_err - ge0, 0);

    // Three-cycle ack latency
    mode = 1; wb0 = wr_q.size(); se0 = stab_err; ge0 = gap_err;
    tick();
    start_a = 1'b1; tick(); start_a = 1'b0; cyc = 1;
    wait_done_a(cyc);
    chk("lat_done_cycles", cyc, 25);  chk("lat_stable", stab_err - se0, 0);
    chk("lat_gap", gap_err - ge0, 0);
    chk("lat_wr0", wr_q[wb0], 64'h0000_0000_2222_1111);
    chk("lat_wr1", wr_q[wb0 + 1], 64'h0000_0004_4444_3333);

    // Ack held high throughout
    mode = 2; tb0 = txn_q.size(); ge0 = gap_err;
    tick();
    start_a = 1'b1; tick(); start_a = 1'b0; cyc = 1;
    wait_done_a(cyc);
    chk("held_done_cycles", cyc, 13); chk("held_ntxn", txn_q.size() - tb0, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("held_addr%0d", i), txn_q[tb0 + i], exp_addr[i]);
    chk("held_gap", gap_err - ge0, 0);

    // No ack: timeout after 10 wait cycles
    mode = 3;
    tick();
    start_a = 1'b1; tick(); start_a = 1'b0; cyc = 1;
    repeat (9) begin tick(); cyc++; end
    chk("to_sel_last_wait", sel_a, 1); chk("to_err_before", err_a, 0);
    tick();
    chk("to_sel_dropped", sel_a, 0);   chk("to_err", err_a, 1);
    chk("to_done", done_a, 0);         chk("to_busy", busy_a, 0);

    // Restart after error clears error and begins at word 0
    mode = 0; wb0 = wr_q.size();
    start_a = 1'b1; tick(); start_a = 1'b0; cyc = 1;
    chk("rs_err_clr", err_a, 0); chk("rs_sel", sel_a, 1); chk("rs_addr", addr_a, 32'h1E00_0000);
    wait_done_a(cyc);
    chk("rs_done_cycles", cyc, 13); chk("rs_wr0", wr_q[wb0], 64'h0000_0000_2222_1111);

    // start while busy is ignored
    wb0 = wr_q.size();
    start_a = 1'b1; tick(); start_a = 1'b0; cyc = 1;
    repeat (3) begin tick(); cyc++; end
    start_a = 1'b1; tick(); cyc++; start_a = 1'b0;
    wait_done_a(cyc);
    chk("sb_done_cycles", cyc, 13); chk("sb_nwr", wr_q.size() - wb0, 2);
    chk("sb_wr1", wr_q[wb0 + 1], 64'h0000_0004_4444_3333);

    // WORD_COUNT = 0
    start_c = 1'b1; tick(); start_c = 1'b0;
    chk("wc0_done", done_c, 1); chk("wc0_busy", busy_c, 0); chk("wc0_sel", sel_c, 0);
    chk("wc0_halt", halt_c, 0); chk("wc0_err", err_c, 0);
    tick();
    chk("wc0_done_held", done_c, 1); chk("wc0_sel_later", sel_c, 0);
    chk("wc0_addr", addr_c, 0);      chk("wc0_we", we_c, 0); chk("wc0_data", dat_c, 0);

    // Reset during RD_HI of word 5
    start_b = 1'b1; tick(); start_b = 1'b0; cyc = 1;
    while (!(sel_b && addr_b == 32'h1E00_002C) && cyc < 100) begin tick(); cyc++; end
    chk("mr_reach_cycle", cyc, 33);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("mr_sel", sel_b, 0);  chk("mr_we", we_b, 0);     chk("mr_addr", addr_b, 0);
    chk("mr_data", dat_b, 0); chk("mr_busy", busy_b, 0); chk("mr_done", done_b, 0);
    chk("mr_err", err_b, 0);  chk("mr_halt", halt_b, 0);
    start_b = 1'b1; tick(); start_b = 1'b0; cyc = 1;
    chk("mr_restart_addr", addr_b, 32'h1E00_0000); chk("mr_restart_sel", sel_b, 1);
    repeat (4) begin tick(); cyc++; end
    chk("mr_wr_we", we_b, 1); chk("mr_wr_addr", addr_b, 0); chk("mr_wr_data", dat_b, 32'h2222_1111);
    while (!done_b && cyc < 300) begin tick(); cyc++; end
    chk("mr_done_cycles", cyc, 37);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
